// File: rtl/evt2_link_pkg.sv
// Shared constants and types for the host-side EVT2-over-UART link.
package evt2_link_pkg;

  localparam logic [7:0] CMD_ECHO   = 8'hFF;
  localparam logic [7:0] CMD_STATUS = 8'hFE;
  localparam logic [7:0] CMD_CONFIG = 8'hFD;
  localparam logic [7:0] CMD_SRESET = 8'hFC;

  localparam logic [7:0] RESP_ECHO   = 8'h55;
  localparam logic [3:0] HDR_GESTURE = 4'hA;
  localparam logic [3:0] HDR_STATUS  = 4'hB;

  typedef enum logic [1:0] {
    CmdEcho   = 2'd0,
    CmdStatus = 2'd1,
    CmdConfig = 2'd2,
    CmdSreset = 2'd3
  } cmd_code_t;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitBusy,
    StGap
  } tx_state_t;

  typedef enum logic [1:0] {
    PIdle,
    PGconf,
    PCfg2
  } rx_state_t;

  function automatic logic [7:0] cmd_byte(cmd_code_t code);
    logic [7:0] b;
    unique case (code)
      CmdEcho:   b = CMD_ECHO;
      CmdStatus: b = CMD_STATUS;
      CmdConfig: b = CMD_CONFIG;
      default:   b = CMD_SRESET;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/evt2_resp_parser.sv
// Parses accelerator response bytes into typed pulses; tracks the outstanding
// command and its response timeout.
module evt2_resp_parser
  import evt2_link_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       cmd_accept,
  input  logic [1:0] cmd_accept_code,
  input  logic       sreset_sent,
  output logic       cmd_pending,
  output logic       gesture_valid,
  output logic [1:0] gesture,
  output logic [3:0] gesture_conf,
  output logic [3:0] evt_cnt_hi,
  output logic       echo_ok,
  output logic       status_valid,
  output logic [2:0] status_bits,
  output logic       config_valid,
  output logic [7:0] cfg_min_thresh,
  output logic [7:0] cfg_motion_thresh,
  output logic       resp_timeout,
  output logic       proto_err
);

  localparam int unsigned TmoW = $clog2(RESP_TIMEOUT + 1);

  rx_state_t       rx_state_q, rx_state_d;
  logic            pend_q, pend_d;
  cmd_code_t       pend_code_q, pend_code_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            tmo_run, tmo_hit, pend_live;
  logic            dec_gesture, dec_echo, dec_status, dec_cfg1, dec_gconf, dec_cfg2, dec_err;

  logic [1:0] gesture_q, gesture_d;
  logic [3:0] conf_q, conf_d, cnt_hi_q, cnt_hi_d;
  logic [2:0] status_bits_q, status_bits_d;
  logic [7:0] cfg_min_q, cfg_min_d, cfg_motion_q, cfg_motion_d;
  logic       gesture_valid_q, echo_ok_q, status_valid_q, config_valid_q;
  logic       resp_timeout_q, proto_err_q;

  assign tmo_run   = pend_q && (rx_state_q == PIdle);
  assign tmo_hit   = tmo_run && (tmo_cnt_q == TmoW'(RESP_TIMEOUT - 1));
  assign pend_live = pend_q && !tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q      <= PIdle;
      pend_q          <= 1'b0;
      pend_code_q     <= CmdEcho;
      tmo_cnt_q       <= '0;
      gesture_q       <= '0;
      conf_q          <= '0;
      cnt_hi_q        <= '0;
      status_bits_q   <= '0;
      cfg_min_q       <= '0;
      cfg_motion_q    <= '0;
      gesture_valid_q <= 1'b0;
      echo_ok_q       <= 1'b0;
      status_valid_q  <= 1'b0;
      config_valid_q  <= 1'b0;
      resp_timeout_q  <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      rx_state_q      <= rx_state_d;
      pend_q          <= pend_d;
      pend_code_q     <= pend_code_d;
      tmo_cnt_q       <= tmo_cnt_d;
      gesture_q       <= gesture_d;
      conf_q          <= conf_d;
      cnt_hi_q        <= cnt_hi_d;
      status_bits_q   <= status_bits_d;
      cfg_min_q       <= cfg_min_d;
      cfg_motion_q    <= cfg_motion_d;
      gesture_valid_q <= dec_gconf;
      echo_ok_q       <= dec_echo;
      status_valid_q  <= dec_status;
      config_valid_q  <= dec_cfg2;
      resp_timeout_q  <= tmo_hit;
      proto_err_q     <= dec_err;
    end
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    pend_d      = pend_q;
    pend_code_d = pend_code_q;
    tmo_cnt_d   = (tmo_run && !tmo_hit) ? tmo_cnt_q + TmoW'(1) : '0;
    dec_gesture = 1'b0;
    dec_echo    = 1'b0;
    dec_status  = 1'b0;
    dec_cfg1    = 1'b0;
    dec_gconf   = 1'b0;
    dec_cfg2    = 1'b0;
    dec_err     = 1'b0;
    if (rx_valid) begin
      unique case (rx_state_q)
        PIdle: begin
          // Gesture headers win over config data, hence the 0xA0-0xA3 threshold hole.
          if (rx_data[7:2] == {HDR_GESTURE, 2'b00}) begin
            dec_gesture = 1'b1;
            rx_state_d  = PGconf;
          end else if (rx_data == RESP_ECHO && pend_live && pend_code_q == CmdEcho) begin
            dec_echo = 1'b1;
          end else if (rx_data[7:4] == HDR_STATUS && pend_live && pend_code_q == CmdStatus) begin
            dec_status = 1'b1;
          end else if (pend_live && pend_code_q == CmdConfig) begin
            dec_cfg1   = 1'b1;
            rx_state_d = PCfg2;
          end else begin
            dec_err = 1'b1;
          end
        end
        PGconf: begin
          dec_gconf  = 1'b1;
          rx_state_d = PIdle;
        end
        PCfg2: begin
          dec_cfg2   = 1'b1;
          rx_state_d = PIdle;
        end
        default: rx_state_d = PIdle;
      endcase
    end
    if (tmo_hit || dec_echo || dec_status || dec_cfg2 || sreset_sent) pend_d = 1'b0;
    if (cmd_accept && cmd_accept_code != CmdSreset) begin
      pend_d      = 1'b1;
      pend_code_d = cmd_code_t'(cmd_accept_code);
    end
  end

  always_comb begin
    gesture_d     = gesture_q;
    conf_d        = conf_q;
    cnt_hi_d      = cnt_hi_q;
    status_bits_d = status_bits_q;
    cfg_min_d     = cfg_min_q;
    cfg_motion_d  = cfg_motion_q;
    if (dec_gesture) gesture_d = rx_data[1:0];
    if (dec_gconf) begin
      conf_d   = rx_data[7:4];
      cnt_hi_d = rx_data[3:0];
    end
    if (dec_status) status_bits_d = rx_data[3:1];
    if (dec_cfg1) cfg_min_d = rx_data;
    if (dec_cfg2) cfg_motion_d = rx_data;
  end

  assign cmd_pending       = pend_q;
  assign gesture_valid     = gesture_valid_q;
  assign gesture           = gesture_q;
  assign gesture_conf      = conf_q;
  assign evt_cnt_hi        = cnt_hi_q;
  assign echo_ok           = echo_ok_q;
  assign status_valid      = status_valid_q;
  assign status_bits       = status_bits_q;
  assign config_valid      = config_valid_q;
  assign cfg_min_thresh    = cfg_min_q;
  assign cfg_motion_thresh = cfg_motion_q;
  assign resp_timeout      = resp_timeout_q;
  assign proto_err         = proto_err_q;

endmodule

// File: rtl/evt2_uart_host_link.sv
// Host-side EVT2-over-UART link: serializes words and command bytes to uart_tx and
// decodes accelerator responses from uart_rx.
module evt2_uart_host_link
  import evt2_link_pkg::*;
#(
  parameter int unsigned WORD_GAP_CYCLES = 16,
  parameter int unsigned RESP_TIMEOUT    = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] evt_word,
  input  logic        evt_valid,
  output logic        evt_ready,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_code,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        gesture_valid,
  output logic [1:0]  gesture,
  output logic [3:0]  gesture_conf,
  output logic [3:0]  evt_cnt_hi,
  output logic        echo_ok,
  output logic        status_valid,
  output logic [2:0]  status_bits,
  output logic        config_valid,
  output logic [7:0]  cfg_min_thresh,
  output logic [7:0]  cfg_motion_thresh,
  output logic        resp_timeout,
  output logic        proto_err,
  output logic [7:0]  drop_count
);

  localparam int unsigned GapW = $clog2(WORD_GAP_CYCLES + 1);

  tx_state_t       tx_state_q, tx_state_d;
  logic [31:0]     shift_q, shift_d;
  logic [1:0]      bytes_left_q, bytes_left_d;
  logic            is_sreset_q, is_sreset_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;
  logic [7:0]      drop_count_q;
  logic            cmd_pending, cmd_fire, evt_fire, word_alias, sreset_sent;

  // Words whose top byte falls in 0xFC-0xFF would be read as commands by the far end.
  assign word_alias  = evt_word[31:24] >= CMD_SRESET;
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign evt_fire    = evt_valid && evt_ready;
  assign sreset_sent = tx_valid && is_sreset_q;
  assign drop_count  = drop_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q   <= StIdle;
      shift_q      <= '0;
      bytes_left_q <= '0;
      is_sreset_q  <= 1'b0;
      gap_cnt_q    <= '0;
      drop_count_q <= '0;
    end else begin
      tx_state_q   <= tx_state_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      is_sreset_q  <= is_sreset_d;
      gap_cnt_q    <= gap_cnt_d;
      if (evt_fire && word_alias && drop_count_q != 8'hFF) drop_count_q <= drop_count_q + 8'd1;
    end
  end

  always_comb begin
    tx_state_d   = tx_state_q;
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    is_sreset_d  = is_sreset_q;
    gap_cnt_d    = gap_cnt_q;
    unique case (tx_state_q)
      StIdle: begin
        if (cmd_fire) begin
          shift_d      = {cmd_byte(cmd_code_t'(cmd_code)), 24'h000000};
          bytes_left_d = 2'd0;
          is_sreset_d  = (cmd_code == CmdSreset);
          tx_state_d   = StSend;
        end else if (evt_fire && !word_alias) begin
          shift_d      = evt_word;
          bytes_left_d = 2'd3;
          is_sreset_d  = 1'b0;
          tx_state_d   = StSend;
        end
      end
      StSend: begin
        if (!tx_busy) tx_state_d = StWaitBusy;
      end
      StWaitBusy: begin
        // Waiting for busy to rise keeps a single tx_valid per byte.
        if (tx_busy) begin
          if (bytes_left_q != 2'd0) begin
            shift_d      = {shift_q[23:0], 8'h00};
            bytes_left_d = bytes_left_q - 2'd1;
            tx_state_d   = StSend;
          end else begin
            gap_cnt_d  = '0;
            tx_state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapW'(WORD_GAP_CYCLES - 1)) tx_state_d = StIdle;
        else gap_cnt_d = gap_cnt_q + GapW'(1);
      end
      default: tx_state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = !rst && (tx_state_q == StIdle) && !cmd_pending;
    evt_ready = !rst && (tx_state_q == StIdle) && !(cmd_valid && cmd_ready);
    tx_valid  = !rst && (tx_state_q == StSend) && !tx_busy;
    tx_data   = tx_valid ? shift_q[31:24] : 8'h00;
  end

  evt2_resp_parser #(
    .RESP_TIMEOUT(RESP_TIMEOUT)
  ) u_parser (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .cmd_accept       (cmd_fire),
    .cmd_accept_code  (cmd_code),
    .sreset_sent      (sreset_sent),
    .cmd_pending      (cmd_pending),
    .gesture_valid    (gesture_valid),
    .gesture          (gesture),
    .gesture_conf     (gesture_conf),
    .evt_cnt_hi       (evt_cnt_hi),
    .echo_ok          (echo_ok),
    .status_valid     (status_valid),
    .status_bits      (status_bits),
    .config_valid     (config_valid),
    .cfg_min_thresh   (cfg_min_thresh),
    .cfg_motion_thresh(cfg_motion_thresh),
    .resp_timeout     (resp_timeout),
    .proto_err        (proto_err)
  );

endmodule

// File: tb/tb_evt2_uart_host_link.sv
// Bench for evt2_uart_host_link: TX bytes are scored against an expected-byte queue,
// response pulses are checked cycle-exactly after each rx byte.
module tb_evt2_uart_host_link;

  localparam int unsigned GAP = 16;
  localparam int unsigned TMO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] evt_word = '0;
  logic        evt_valid = 1'b0;
  logic        evt_ready;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_code = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        gesture_valid;
  logic [1:0]  gesture;
  logic [3:0]  gesture_conf;
  logic [3:0]  evt_cnt_hi;
  logic        echo_ok;
  logic        status_valid;
  logic [2:0]  status_bits;
  logic        config_valid;
  logic [7:0]  cfg_min_thresh;
  logic [7:0]  cfg_motion_thresh;
  logic        resp_timeout;
  logic        proto_err;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int last_tx_cyc = 0;
  int n_tx = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  evt2_uart_host_link #(
    .WORD_GAP_CYCLES(GAP),
    .RESP_TIMEOUT   (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .evt_word         (evt_word),
    .evt_valid        (evt_valid),
    .evt_ready        (evt_ready),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_code         (cmd_code),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_busy          (tx_busy),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .gesture_valid    (gesture_valid),
    .gesture          (gesture),
    .gesture_conf     (gesture_conf),
    .evt_cnt_hi       (evt_cnt_hi),
    .echo_ok          (echo_ok),
    .status_valid     (status_valid),
    .status_bits      (status_bits),
    .config_valid     (config_valid),
    .cfg_min_thresh   (cfg_min_thresh),
    .cfg_motion_thresh(cfg_motion_thresh),
    .resp_timeout     (resp_timeout),
    .proto_err        (proto_err),
    .drop_count       (drop_count)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy for 10 cycles after each accepted byte
  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (tx_valid) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Scoreboard: every transmitted byte must match the next expected byte.
  always @(negedge clk) begin
    if (tx_valid) begin
      last_tx_cyc = cyc;
      n_tx++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got %02h want none", tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (tx_data !== mon_exp) begin
          errors++;
          $display("FAIL tx_byte got %02h want %02h", tx_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    evt_valid = 1'b0;
    cmd_valid = 1'b0;
    rx_valid = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic offer_word(input logic [31:0] w, output int hs_cyc, output bit ok);
    evt_word = w;
    evt_valid = 1'b1;
    ok = 1'b0;
    hs_cyc = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      #1;
      if (evt_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
      end
      tick();
    end
    evt_valid = 1'b0;
    if (ok && w[31:24] < 8'hFC) begin
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic offer_cmd(input logic [1:0] code, output int hs_cyc, output bit ok);
    logic [7:0] b;
    cmd_code = code;
    cmd_valid = 1'b1;
    ok = 1'b0;
    hs_cyc = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      #1;
      if (cmd_ready) begin
        ok = 1'b1;
        hs_cyc = cyc;
      end
      tick();
    end
    cmd_valid = 1'b0;
    case (code)
      2'd0:    b = 8'hFF;
      2'd1:    b = 8'hFE;
      2'd2:    b = 8'hFD;
      default: b = 8'hFC;
    endcase
    if (ok) exp_q.push_back(b);
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      if (exp_q.size() == 0) ok = 1'b1;
      else tick();
    end
    repeat (40) tick();
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (tx_valid !== 1'b0 || evt_ready !== 1'b0 || cmd_ready !== 1'b0 || drop_count !== 8'd0 ||
        gesture_valid !== 1'b0 || proto_err !== 1'b0 || resp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got tx_valid=%b evt_ready=%b cmd_ready=%b drop=%0d want all 0",
               tx_valid, evt_ready, cmd_ready, drop_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (evt_ready !== 1'b1 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got evt_ready=%b cmd_ready=%b want 1 1", evt_ready, cmd_ready);
    end
  endtask

  task automatic test_word_serialization();
    int h1, h2, n0;
    bit ok;
    do_reset();
    n0 = n_tx;
    offer_word(32'h1234_5678, h1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL word_accept got 0 want 1"); end
    checks++;
    if (tx_valid !== 1'b1) begin
      errors++;
      $display("FAIL word_latency got tx_valid=%b want 1", tx_valid);
    end
    offer_word(32'h0A0B_0C0D, h2, ok);
    checks++;
    if (!ok || (h2 - last_tx_cyc - 1) < int'(GAP)) begin
      errors++;
      $display("FAIL word_gap got %0d idle cycles want >= %0d", h2 - last_tx_cyc - 1, GAP);
    end
    wait_drain(ok);
    checks++;
    if (!ok || n_tx - n0 != 8) begin
      errors++;
      $display("FAIL word_tx_count got %0d want 8", n_tx - n0);
    end
  endtask

  task automatic test_alias_reject();
    int h, n0;
    bit ok;
    do_reset();
    n0 = n_tx;
    offer_word(32'hFD00_0001, h, ok);
    checks++;
    if (!ok || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL alias_drop got %0d want 1", drop_count);
    end
    repeat (20) tick();
    checks++;
    if (n_tx != n0) begin errors++; $display("FAIL alias_no_tx got %0d want 0", n_tx - n0); end
    for (int i = 0; i < 255; i++) offer_word(32'hFC00_0000 | i, h, ok);
    checks++;
    if (drop_count !== 8'd255 || evt_ready !== 1'b1) begin
      errors++;
      $display("FAIL alias_saturate got drop=%0d ready=%b want 255 1", drop_count, evt_ready);
    end
  endtask

  task automatic test_echo_cmd();
    int h;
    bit ok;
    do_reset();
    evt_word = 32'h1122_3344;
    evt_valid = 1'b1;
    cmd_code = 2'd0;
    cmd_valid = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || evt_ready !== 1'b0) begin
      errors++;
      $display("FAIL echo_priority got cmd_ready=%b evt_ready=%b want 1 0", cmd_ready, evt_ready);
    end
    tick();
    cmd_valid = 1'b0;
    exp_q.push_back(8'hFF);
    offer_word(32'h1122_3344, h, ok);
    wait_drain(ok);
    checks++;
    if (!ok || cmd_ready !== 1'b0 || evt_ready !== 1'b1) begin
      errors++;
      $display("FAIL echo_outstanding got cmd_ready=%b evt_ready=%b want 0 1", cmd_ready, evt_ready);
    end
    rx_byte(8'h55);
    checks++;
    if (echo_ok !== 1'b1 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL echo_ok got %b want 1", echo_ok);
    end
    tick();
    checks++;
    if (echo_ok !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL echo_done got echo_ok=%b cmd_ready=%b want 0 1", echo_ok, cmd_ready);
    end
  endtask

  task automatic test_gesture();
    rx_byte(8'hA2);
    checks++;
    if (gesture_valid !== 1'b0) begin
      errors++;
      $display("FAIL gesture_early got %b want 0", gesture_valid);
    end
    rx_byte(8'h93);
    checks++;
    if (gesture_valid !== 1'b1 || gesture !== 2'd2 || gesture_conf !== 4'd9 || evt_cnt_hi !== 4'd3) begin
      errors++;
      $display("FAIL gesture_fields got v=%b g=%0d c=%0d n=%0d want 1 2 9 3",
               gesture_valid, gesture, gesture_conf, evt_cnt_hi);
    end
    tick();
    checks++;
    if (gesture_valid !== 1'b0 || gesture_conf !== 4'd9) begin
      errors++;
      $display("FAIL gesture_hold got v=%b c=%0d want 0 9", gesture_valid, gesture_conf);
    end
  endtask

  task automatic test_config();
    int h;
    bit ok;
    offer_cmd(2'd2, h, ok);
    wait_drain(ok);
    rx_byte(8'h14);
    checks++;
    if (config_valid !== 1'b0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL config_early got v=%b err=%b want 0 0", config_valid, proto_err);
    end
    rx_byte(8'h08);
    checks++;
    if (config_valid !== 1'b1 || cfg_min_thresh !== 8'd20 || cfg_motion_thresh !== 8'd8) begin
      errors++;
      $display("FAIL config_fields got v=%b min=%0d mot=%0d want 1 20 8",
               config_valid, cfg_min_thresh, cfg_motion_thresh);
    end
    tick();
    checks++;
    if (config_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL config_done got v=%b cmd_ready=%b want 0 1", config_valid, cmd_ready);
    end
  endtask

  task automatic test_status_timeout();
    int h, hit_cyc;
    bit ok, seen;
    offer_cmd(2'd1, h, ok);
    wait_drain(ok);
    rx_byte(8'hB5);
    checks++;
    if (status_valid !== 1'b1 || status_bits !== 3'b010) begin
      errors++;
      $display("FAIL status_fields got v=%b bits=%b want 1 010", status_valid, status_bits);
    end
    offer_cmd(2'd1, h, ok);
    seen = 1'b0;
    hit_cyc = 0;
    for (int i = 0; i < int'(2 * TMO) && !seen; i++) begin
      if (resp_timeout === 1'b1) begin
        seen = 1'b1;
        hit_cyc = cyc;
      end else begin
        tick();
      end
    end
    checks++;
    if (!seen || hit_cyc - h < int'(TMO) - 1 || hit_cyc - h > int'(TMO) + 2) begin
      errors++;
      $display("FAIL timeout_latency got seen=%b after %0d want about %0d", seen, hit_cyc - h, TMO);
    end
    tick();
    checks++;
    if (resp_timeout !== 1'b0 || cmd_ready !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_done got pulse=%b cmd_ready=%b want 0 1", resp_timeout, cmd_ready);
    end
  endtask

  task automatic test_proto_err();
    rx_byte(8'h55);
    checks++;
    if (proto_err !== 1'b1 || echo_ok !== 1'b0) begin
      errors++;
      $display("FAIL proto_err got err=%b echo=%b want 1 0", proto_err, echo_ok);
    end
    tick();
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_err_width got 1 want 0"); end
  endtask

  task automatic test_soft_reset();
    int h;
    bit ok;
    offer_cmd(2'd3, h, ok);
    wait_drain(ok);
    checks++;
    if (!ok || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL sreset_ready got drained=%b cmd_ready=%b want 1 1", ok, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_word();
    int h, n0;
    bit ok;
    do_reset();
    n0 = n_tx;
    offer_word(32'h0102_0304, h, ok);
    for (int i = 0; i < 200 && (n_tx - n0) < 2; i++) tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL midword_tx_valid got 1 want 0"); end
    tick();
    rst = 1'b0;
    repeat (80) tick();
    checks++;
    if (n_tx - n0 != 2 || evt_ready !== 1'b1) begin
      errors++;
      $display("FAIL midword_bytes got %0d ready=%b want 2 1", n_tx - n0, evt_ready);
    end
  endtask

  initial begin
    test_reset();
    test_word_serialization();
    test_alias_reject();
    test_echo_cmd();
    test_gesture();
    test_config();
    test_status_timeout();
    test_proto_err();
    test_soft_reset();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/evt2_uart_host_link.md
# evt2_uart_host_link

Host-side UART link controller for the voxel-bin gesture accelerator: it drives the far end of the accelerator's EVT2-over-UART protocol. It serializes 32-bit EVT2 words MSB-first into a byte-level UART transmitter and issues echo, status, config and soft-reset command bytes. It also parses the accelerator's response bytes into typed pulses. It sits in the replay/loopback FPGA, between an event source (flash replay or pattern generator) and `uart_tx`/`uart_rx`.

## Interface
- `WORD_GAP_CYCLES`, 16: minimum idle cycles after the last byte of a word before the next word or command is accepted.
- `RESP_TIMEOUT`, 2_000_000: cycles an outstanding echo, status or config command may wait for its response.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `evt_word` in 32: EVT2 word to send.
- `evt_valid` in 1 / `evt_ready` out 1: word handshake.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_code` in 2: 0 = echo (0xFF), 1 = status (0xFE), 2 = config (0xFD), 3 = soft reset (0xFC).
- `tx_data` out 8, `tx_valid` out 1, `tx_busy` in 1: byte interface to `uart_tx`.
- `rx_data` in 8, `rx_valid` in 1: byte interface from `uart_rx`.
- `gesture_valid` out 1: 1-cycle pulse, accompanied by `gesture` out 2, `gesture_conf` out 4 and `evt_cnt_hi` out 4.
- `echo_ok` out 1: pulse.
- `status_valid` out 1: pulse, with `status_bits` out 3 = {temporal_phase, fifo_full, fifo_empty}.
- `config_valid` out 1: pulse, with `cfg_min_thresh` out 8 and `cfg_motion_thresh` out 8.
- `resp_timeout` out 1: pulse. `proto_err` out 1: pulse.
- `drop_count` out 8: saturating count of rejected words.

## Operation
- **TX FSM states:**
  - S_IDLE → S_SEND → S_WAIT_BUSY → (S_SEND for next byte | S_GAP) → S_IDLE.
  - A word is 4 bytes; a command is 1 byte.
- **S_SEND:** if `!tx_busy`, drive `tx_data` and pulse `tx_valid` for one cycle, then enter S_WAIT_BUSY.
- **S_WAIT_BUSY:** advance when `tx_busy` is seen high. This guarantees exactly one `tx_valid` pulse per byte.
- **Byte order:** [31:24], [23:16], [15:8], [7:0].
- **S_GAP:** count `WORD_GAP_CYCLES`, then return to S_IDLE. The gap applies after both words and commands.
- **Word rejection:** a word with `evt_word[31:24]` ≥ 0xFC would alias a command byte.
  - It is accepted (handshake completes), produces no bytes, and increments `drop_count` (saturating at 255).
  - The FSM stays in S_IDLE.
- **`evt_ready`:** = (state == S_IDLE) && !(`cmd_valid` && `cmd_ready`). Commands win simultaneous arrival.
- **`cmd_ready`:** = (state == S_IDLE) && no command outstanding.
  - Echo, status and config become outstanding when accepted.
  - Soft reset is never outstanding; it completes when its byte is sent.
- Words may stream while a command is outstanding.
- **Response parser states:** P_IDLE, P_GCONF, P_CFG2.
- **In P_IDLE:**
  - 0xA0–0xA3 → latch `gesture` = `rx_data[1:0]`, go to P_GCONF.
  - 0x55 with echo outstanding → `echo_ok`, clear outstanding.
  - `rx_data[7:4]` == 0xB with status outstanding → `status_valid`, `status_bits` = `rx_data[3:1]`, clear outstanding.
  - Any other byte with config outstanding → latch `cfg_min_thresh`, go to P_CFG2.
  - Anything else → `proto_err`.
- **P_GCONF:** next byte → `gesture_conf` = [7:4], `evt_cnt_hi` = [3:0], `gesture_valid` pulse, return to P_IDLE.
- **P_CFG2:** next byte → `cfg_motion_thresh`, `config_valid` pulse, clear outstanding, return to P_IDLE.
- **Threshold limitation:** config thresholds 0xA0–0xA3 are unsupported, because they are parsed as gesture headers.
- **Timeout:** the counter runs while a command is outstanding and in the parser's P_IDLE. On reaching `RESP_TIMEOUT`: `resp_timeout` pulse, clear outstanding, parser to P_IDLE.
- **Soft-reset interaction:** after sending 0xFC, any outstanding command is cleared silently, since the accelerator drops pending responses.

## Timing
- **Reset:** all outputs 0, `drop_count` 0, FSMs in S_IDLE/P_IDLE, no command outstanding.
  - `evt_ready` and `cmd_ready` are 1 in the first cycle after reset deasserts.
  - A reset mid-word abandons the remaining bytes; `tx_valid` is 0 on the cycle after `rst`.
- **Word/command latency:** handshake in cycle N → first `tx_valid` in cycle N+1 if `tx_busy` is low.
- **Response latency:** `rx_valid` in cycle N → response pulse in cycle N+1. Data outputs hold until the next update.
- **Pulse width:** all `*_valid`, `echo_ok`, `resp_timeout` and `proto_err` pulses are exactly one cycle.
- **RX/TX independence:** RX parsing is fully independent of the TX FSM; simultaneous `rx_valid` and TX activity must both be honoured.

## Structure
- **`evt2_link_pkg`:**
  - Command byte constants (0xFF/FE/FD/FC).
  - `RESP_ECHO` = 0x55.
  - Gesture header 0xA, status header 0xB.
  - `cmd_code_t` enum, TX/parser state enums.
- **Sub-module `evt2_resp_parser`:** P_* FSM, outstanding tracking inputs, timeout counter. The top holds the TX FSM, gap counter and `drop_count`.

## Test plan
- **Word serialization:** word 0x1234_5678, `tx_busy` modelled 10 cycles per byte → bytes 0x12, 0x34, 0x56, 0x78, one `tx_valid` each; next word not accepted before `WORD_GAP_CYCLES` elapse.
- **Aliasing word rejected:** word 0xFD00_0001 → no `tx_valid`, `drop_count` = 1; 256 such words → `drop_count` stays 255.
- **Echo command:** echo `cmd_code` with simultaneous `evt_valid` → 0xFF sent first; `rx` 0x55 → `echo_ok` pulse, `cmd_ready` returns to 1.
- **Gesture response:** rx 0xA2 then 0x93 (no command outstanding) → `gesture_valid`, `gesture` = 2, `gesture_conf` = 9, `evt_cnt_hi` = 3.
- **Config command:** config `cmd_code`, rx 0x14 then 0x08 → `config_valid`, `cfg_min_thresh` = 20, `cfg_motion_thresh` = 8.
- **Timeout and reset cases:**
  - Status command with no reply → `resp_timeout` after `RESP_TIMEOUT` cycles.
  - Unexpected rx 0x55 → `proto_err`.
  - `rst` after byte 2 of a word → no further bytes sent.
